// File: rtl/sa_pkg.sv
// Shared types and job-length helpers for the systolic-array sequencing controller.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sa_state_e;

  function automatic int unsigned max_rc(input int unsigned rows, input int unsigned cols);
    return (rows > cols) ? rows : cols;
  endfunction

  // Feed phase length: the last operand enters the farthest edge lane on cycle F-1.
  function automatic int unsigned feed_len(input int unsigned k, input int unsigned rows,
                                           input int unsigned cols);
    return k + max_rc(rows, cols) - 1;
  endfunction

  // Drain phase length: the last partial sum ripples across the full array diagonal.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// Diagonal skew generator: lane i is enabled for k_q cycles starting at t == i.
module sa_skew_gen #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int TW = KW + 1
) (
  input  logic [TW-1:0] t,
  input  logic [KW-1:0] k_q,
  output logic [N-1:0]  en,
  output logic [N-1:0]  clr
);

  // One extra bit keeps i + k_q from wrapping for any lane index.
  logic [TW:0] t_x;
  assign t_x = {1'b0, t};

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [TW:0] lo;
    logic [TW:0] hi;
    assign lo     = (TW+1)'(i);
    assign hi     = lo + (TW+1)'(k_q);
    assign en[i]  = (t_x >= lo) && (t_x < hi);
    assign clr[i] = (t_x == lo);
  end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array: skewed operand feed, drain, done pulse.
// Handshake: a job is accepted on a rising edge where start=1 and ready=1; start
// while ready=0 is dropped, never queued. abort cancels FEED/DRAIN on the next edge.
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] row_en,
  output logic [ROWS-1:0] row_clr,
  output logic [ROWS-1:0] row_zero,
  output logic [COLS-1:0] col_en,
  output sa_state_e       state_dbg
);

  localparam int TW     = KW + 1;
  localparam int D_LEN  = int'(drain_len(ROWS, COLS));
  localparam int DW     = $clog2(D_LEN + 1);
  localparam logic [DW-1:0] D_LAST = DW'(D_LEN - 1);

  sa_state_e     state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0] f_last;

  assign f_last = TW'(feed_len(32'(k_q), ROWS, COLS) - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = k_len;
          t_d     = '0;
          dcnt_d  = '0;
          state_d = (k_len == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        // abort outranks the feed-complete transition
        if (abort) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
          if (t_q == f_last) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [ROWS-1:0] row_en_raw, row_clr_raw;
  logic [COLS-1:0] col_en_raw, col_clr_unused;
  logic            in_feed;

  sa_skew_gen #(.N(ROWS), .KW(KW), .TW(TW)) u_row_skew (
    .t   (t_q),
    .k_q (k_q),
    .en  (row_en_raw),
    .clr (row_clr_raw)
  );

  sa_skew_gen #(.N(COLS), .KW(KW), .TW(TW)) u_col_skew (
    .t   (t_q),
    .k_q (k_q),
    .en  (col_en_raw),
    .clr (col_clr_unused)
  );

  // Outputs decode straight from registered state so reset takes effect immediately.
  assign in_feed   = (state_q == ST_FEED);
  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign row_en    = in_feed ? row_en_raw  : '0;
  assign row_clr   = in_feed ? row_clr_raw : '0;
  assign row_zero  = ~row_en;
  assign col_en    = in_feed ? col_en_raw  : '0;
  assign state_dbg = state_q;

endmodule

// File: doc/sa_seq_ctrl.md
SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 4: number of array rows fed through the horizontal buffer chain.
REQ-002 Parameter COLS, default 4: number of array columns fed through the vertical buffer chain.
REQ-003 Parameter KW, default 8: width of the dot-product length field.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: job request; accepted only when ready=1.
REQ-007 Port k_len, input, KW: dot-product length; sampled on acceptance.
REQ-008 Port abort, input, 1: synchronous job cancel.
REQ-009 Port ready, output, 1: high only in IDLE.
REQ-010 Port busy, output, 1: high in FEED or DRAIN.
REQ-011 Port done, output, 1: single-cycle completion pulse.
REQ-012 Port row_en, output, ROWS: per-row operand fetch/shift enable.
REQ-013 Port row_clr, output, ROWS: per-row accumulate-clear; drives the c field of the horizontal links.
REQ-014 Port row_zero, output, ROWS: per-row bubble flag; drives the z field of the horizontal links.
REQ-015 Port col_en, output, COLS: per-column operand fetch/shift enable for the vertical links.

Function
REQ-016 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE.
REQ-017 IDLE -> FEED SHALL occur on start=1 with k_len>0; k_len is latched into k_q and t is cleared to 0.
REQ-018 IDLE -> DONE SHALL occur on start=1 with k_len=0; no enable is asserted for that job.
REQ-019 FEED: t SHALL increment every cycle; the block SHALL leave FEED after F = k_q + max(ROWS,COLS) - 1 cycles (t = F-1 is the last).
REQ-020 FEED: row_en[r] = (t >= r) && (t < r + k_q); col_en[j] = (t >= j) && (t < j + k_q); this gives the diagonal skew.
REQ-021 FEED: row_clr[r] = (t == r); row_zero[r] = !row_en[r].
REQ-022 DRAIN: the block SHALL hold for D = ROWS + COLS - 1 cycles with all row_en, col_en and row_clr low and all row_zero high, then go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Outside FEED, row_en, col_en and row_clr SHALL be 0 and row_zero SHALL be all-ones.
REQ-025 start while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-026 abort=1 in FEED or DRAIN SHALL force IDLE on the next edge, with all enables 0 and no done pulse.
REQ-027 abort=1 has priority over a FEED/DRAIN terminal transition in the same cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Counter t SHALL be KW+1 bits wide so that t = k_q + max(ROWS,COLS) - 1 never wraps; the drain counter SHALL be sized for ROWS+COLS-1.

Reset
REQ-030 rst=0 SHALL force, asynchronously: IDLE, t=0, k_q=0, ready=1, busy=0, done=0, row_en=0, col_en=0, row_clr=0, row_zero=all-ones.
REQ-031 Reset asserted mid-job SHALL abandon the job with no done pulse; operation resumes on the first edge after rst returns to 1.

Structure
REQ-032 The state enum, and the F and D length functions, SHALL live in shared package sa_pkg.
REQ-033 The skew compare of REQ-020 and REQ-021 SHALL be one sub-module, sa_skew_gen (parameter N, inputs t and k_q, outputs en[N] and clr[N]), instantiated once for rows and once for columns.

Verification
REQ-034 ROWS=COLS=4, k_len=3, start at cycle 0 -> FEED for cycles 1-6, DRAIN for cycles 7-13, done=1 at cycle 14 only, ready=1 at cycle 15.
REQ-035 Same configuration -> row_en[3] high for cycles 4-6 only; row_clr[2] high at cycle 3 only; row_zero[0]=0 for cycles 1-3.
REQ-036 k_len=0 start -> done at cycle 1; row_en and col_en never asserted.
REQ-037 start pulsed during FEED -> ignored; exactly one done pulse per accepted job.
REQ-038 abort at cycle 3 of a k_len=5 job -> IDLE at cycle 4, all enables 0, no done; a new start at cycle 5 is accepted.
REQ-039 rst=0 asserted mid-DRAIN (asynchronously) -> all outputs take their REQ-030 reset values immediately; no done pulse.
